// File: rtl/wb_arb2_pkg.sv
// rtl/wb_arb2_pkg.sv - shared types and widths for the two-master Wishbone arbiter
package wb_arb2_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;
  localparam int TMR_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/wb_arb2_timer.sv
// rtl/wb_arb2_timer.sv - response timeout counter for one outstanding transfer
module wb_arb2_timer
  import wb_arb2_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [TMR_W-1:0] count_q, count_d;

  // Fires in the TIMEOUT-th enabled cycle so the error lands one cycle later,
  // mirroring the latency of a real slave response.
  assign expired_o = enable_i && (count_q == TMR_W'(TIMEOUT - 1));

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !expired_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/wb_arb2.sv
// rtl/wb_arb2.sv - two-master round-robin Wishbone arbiter onto one slave, one transfer at a time
module wb_arb2
  import wb_arb2_pkg::*;
#(
  parameter int          ADDR_WIDTH = 3,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,

  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [WB_SEL_W-1:0]   m0_sel_i,
  input  logic [WB_DATA_W-1:0]  m0_dat_i,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  output logic                  m0_rty_o,
  output logic                  m0_stall_o,
  output logic [WB_DATA_W-1:0]  m0_dat_o,

  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [WB_SEL_W-1:0]   m1_sel_i,
  input  logic [WB_DATA_W-1:0]  m1_dat_i,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  m1_rty_o,
  output logic                  m1_stall_o,
  output logic [WB_DATA_W-1:0]  m1_dat_o,

  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [WB_SEL_W-1:0]   s_sel_o,
  output logic [WB_DATA_W-1:0]  s_dat_o,
  input  logic                  s_ack_i,
  input  logic                  s_err_i,
  input  logic                  s_rty_i,
  input  logic                  s_stall_i,
  input  logic [WB_DATA_W-1:0]  s_dat_i
);

  state_e                state_q, state_d;
  logic                  last_q, last_d;
  logic                  grant_q, grant_d;
  logic                  aband_q, aband_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [WB_SEL_W-1:0]   sel_q, sel_d;
  logic                  we_q, we_d;
  logic [WB_DATA_W-1:0]  wdat_q, wdat_d;
  logic [1:0]            ack_q, ack_d;
  logic [1:0]            err_q, err_d;
  logic [WB_DATA_W-1:0]  rdat0_q, rdat0_d;
  logic [WB_DATA_W-1:0]  rdat1_q, rdat1_d;

  logic                  req0, req1;
  logic                  gnt_valid, gnt_idx;
  logic                  gm_cyc;
  logic                  tmr_clear, tmr_en, tmr_expired;
  logic                  finish, fin_err;
  logic [WB_DATA_W-1:0]  fin_dat;
  logic                  unused_rty;

  assign req0      = m0_cyc_i & m0_stb_i;
  assign req1      = m1_cyc_i & m1_stb_i;
  // Reset suppresses the grant so requesters see stall while rst_n_i is low.
  assign gnt_valid = rst_n_i & (state_q == ST_IDLE) & (req0 | req1);
  assign gnt_idx   = (req0 & req1) ? ~last_q : req1;
  assign gm_cyc    = grant_q ? m1_cyc_i : m0_cyc_i;
  assign tmr_en    = (state_q != ST_IDLE);

  wb_arb2_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clear_i   (tmr_clear),
    .enable_i  (tmr_en),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    aband_d   = aband_q;
    adr_d     = adr_q;
    sel_d     = sel_q;
    we_d      = we_q;
    wdat_d    = wdat_q;
    ack_d     = 2'b00;
    err_d     = 2'b00;
    rdat0_d   = '0;
    rdat1_d   = '0;
    tmr_clear = 1'b0;
    finish    = 1'b0;
    fin_err   = 1'b0;
    fin_dat   = '0;

    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          grant_d   = gnt_idx;
          aband_d   = 1'b0;
          adr_d     = gnt_idx ? m1_adr_i : m0_adr_i;
          sel_d     = gnt_idx ? m1_sel_i : m0_sel_i;
          we_d      = gnt_idx ? m1_we_i  : m0_we_i;
          wdat_d    = gnt_idx ? m1_dat_i : m0_dat_i;
          tmr_clear = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE, ST_WAIT: begin
        if (!gm_cyc) begin
          aband_d = 1'b1;
        end
        if (s_ack_i || s_err_i) begin
          finish  = 1'b1;
          fin_err = s_err_i;
          fin_dat = s_dat_i;
        end else if (tmr_expired) begin
          finish  = 1'b1;
          fin_err = 1'b1;
        end else if ((state_q == ST_ISSUE) && !s_stall_i) begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A master that let go of cyc at any point forfeits its response.
    if (finish) begin
      state_d = ST_IDLE;
      last_d  = grant_q;
      if (gm_cyc && !aband_q) begin
        if (grant_q) begin
          ack_d[1] = ~fin_err;
          err_d[1] = fin_err;
          rdat1_d  = fin_dat;
        end else begin
          ack_d[0] = ~fin_err;
          err_d[0] = fin_err;
          rdat0_d  = fin_dat;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      grant_q <= 1'b0;
      aband_q <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      wdat_q  <= '0;
      ack_q   <= 2'b00;
      err_q   <= 2'b00;
      rdat0_q <= '0;
      rdat1_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      aband_q <= aband_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      wdat_q  <= wdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdat0_q <= rdat0_d;
      rdat1_q <= rdat1_d;
    end
  end

  assign s_cyc_o    = (state_q != ST_IDLE);
  assign s_stb_o    = (state_q == ST_ISSUE);
  assign s_we_o     = we_q;
  assign s_adr_o    = adr_q;
  assign s_sel_o    = sel_q;
  assign s_dat_o    = wdat_q;

  assign m0_stall_o = req0 & ~(gnt_valid & ~gnt_idx);
  assign m1_stall_o = req1 & ~(gnt_valid & gnt_idx);
  assign m0_ack_o   = ack_q[0];
  assign m1_ack_o   = ack_q[1];
  assign m0_err_o   = err_q[0];
  assign m1_err_o   = err_q[1];
  assign m0_dat_o   = rdat0_q;
  assign m1_dat_o   = rdat1_q;
  assign m0_rty_o   = 1'b0;
  assign m1_rty_o   = 1'b0;

  assign unused_rty = s_rty_i;

endmodule

// File: tb/tb_wb_arb2.sv
// tb/tb_wb_arb2.sv - self-checking bench for wb_arb2
module tb_wb_arb2;

  localparam int AW = 3;
  localparam int TO = 8;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic m0_cyc, m0_stb, m0_we, m0_ack, m0_err, m0_rty, m0_stall;
  logic [AW-1:0] m0_adr;
  logic [3:0] m0_sel;
  logic [31:0] m0_wdat, m0_rdat;
  logic m1_cyc, m1_stb, m1_we, m1_ack, m1_err, m1_rty, m1_stall;
  logic [AW-1:0] m1_adr;
  logic [3:0] m1_sel;
  logic [31:0] m1_wdat, m1_rdat;
  logic s_cyc, s_stb, s_we, s_ack, s_err, s_rty, s_stall;
  logic [AW-1:0] s_adr;
  logic [3:0] s_sel;
  logic [31:0] s_wdat, s_rdat;

  wb_arb2 #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_sel_i(m0_sel), .m0_dat_i(m0_wdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m0_rty_o(m0_rty), .m0_stall_o(m0_stall), .m0_dat_o(m0_rdat),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_sel_i(m1_sel), .m1_dat_i(m1_wdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .m1_rty_o(m1_rty), .m1_stall_o(m1_stall), .m1_dat_o(m1_rdat),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr),
    .s_sel_o(s_sel), .s_dat_o(s_wdat), .s_ack_i(s_ack), .s_err_i(s_err),
    .s_rty_i(s_rty), .s_stall_i(s_stall), .s_dat_i(s_rdat)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level reference: one outstanding transfer, its owner, its age.
  logic md_busy, md_issued, md_dropped, md_owner, md_last, md_we;
  int md_age;
  logic [AW-1:0] md_adr;
  logic [3:0] md_sel;
  logic [31:0] md_wd;
  logic [1:0] ex_ack, ex_err;
  logic [31:0] ex_dat [2];

  task automatic model_reset();
    md_busy = 0; md_issued = 0; md_dropped = 0; md_owner = 0; md_last = 1;
    md_age = 0; md_we = 0; md_adr = '0; md_sel = '0; md_wd = '0;
    ex_ack = '0; ex_err = '0; ex_dat[0] = '0; ex_dat[1] = '0;
  endtask

  task automatic model_check();
    logic r0, r1, win;
    r0 = m0_cyc & m0_stb;
    r1 = m1_cyc & m1_stb;
    win = (r0 && r1) ? ~md_last : r1;
    chk1("model s_cyc", s_cyc, md_busy);
    chk1("model s_stb", s_stb, md_busy && !md_issued);
    chk1("model m0_stall", m0_stall, r0 && !(rst_n && !md_busy && win == 1'b0));
    chk1("model m1_stall", m1_stall, r1 && !(rst_n && !md_busy && win == 1'b1));
    chk1("model m0_ack", m0_ack, ex_ack[0]);
    chk1("model m1_ack", m1_ack, ex_ack[1]);
    chk1("model m0_err", m0_err, ex_err[0]);
    chk1("model m1_err", m1_err, ex_err[1]);
    chk32("model m0_dat", m0_rdat, ex_dat[0]);
    chk32("model m1_dat", m1_rdat, ex_dat[1]);
    chk1("model m0_rty", m0_rty, 1'b0);
    chk1("model m1_rty", m1_rty, 1'b0);
    if (md_busy) begin
      chk32("model s_adr", 32'(s_adr), 32'(md_adr));
      chk32("model s_sel", 32'(s_sel), 32'(md_sel));
      chk1("model s_we", s_we, md_we);
      chk32("model s_dat", s_wdat, md_wd);
    end
  endtask

  task automatic model_step();
    logic r0, r1, oc, done, derr;
    logic [31:0] ddat;
    r0 = m0_cyc & m0_stb;
    r1 = m1_cyc & m1_stb;
    ex_ack = '0; ex_err = '0; ex_dat[0] = '0; ex_dat[1] = '0;
    done = 0; derr = 0; ddat = '0;
    if (!rst_n) begin
      model_reset();
    end else if (!md_busy) begin
      if (r0 || r1) begin
        md_owner = (r0 && r1) ? ~md_last : r1;
        md_adr = md_owner ? m1_adr : m0_adr;
        md_sel = md_owner ? m1_sel : m0_sel;
        md_we  = md_owner ? m1_we : m0_we;
        md_wd  = md_owner ? m1_wdat : m0_wdat;
        md_busy = 1; md_issued = 0; md_age = 0; md_dropped = 0;
      end
    end else begin
      md_age++;
      oc = md_owner ? m1_cyc : m0_cyc;
      if (!oc) md_dropped = 1;
      if (s_ack || s_err) begin
        done = 1; derr = s_err; ddat = s_rdat;
      end else if (md_age == TO) begin
        done = 1; derr = 1;
      end else if (!s_stall) begin
        md_issued = 1;
      end
      if (done) begin
        md_busy = 0;
        md_last = md_owner;
        if (!md_dropped) begin
          ex_ack[md_owner] = ~derr;
          ex_err[md_owner] = derr;
          ex_dat[md_owner] = ddat;
        end
      end
    end
  endtask

  task automatic finish_cycle();
    model_check();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst_n = 1; m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_sel = 4'hF; m0_wdat = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = 3'd6; m1_sel = 4'h3; m1_wdat = 32'h33;
    s_ack = 0; s_err = 0; s_rty = 0; s_stall = 0; s_rdat = '0;
  endtask

  typedef struct packed {
    logic rst; logic c0; logic s0; logic we0; logic [2:0] adr0; logic [31:0] d0;
    logic c1; logic s1; logic ack; logic [31:0] sdat;
    logic e_cyc; logic e_stb; logic e_st0; logic e_st1; logic e_ack0; logic e_ack1;
    logic [31:0] e_dat0; logic [31:0] e_dat1;
  } vec_t;

  vec_t tbl[$];

  initial begin
    idle_inputs();
    model_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;

    tbl.push_back('{L,H,H,L,3'd0,32'h0,  L,L,L,32'h0,  L,L,H,L,L,L,32'h0,32'h0});
    tbl.push_back('{H,H,H,H,3'd4,32'h15, L,L,L,32'h0,  L,L,L,L,L,L,32'h0,32'h0});
    tbl.push_back('{H,H,L,H,3'd4,32'h15, L,L,L,32'h0,  H,H,L,L,L,L,32'h0,32'h0});
    tbl.push_back('{H,H,L,H,3'd4,32'h15, L,L,L,32'h0,  H,L,L,L,L,L,32'h0,32'h0});
    tbl.push_back('{H,H,L,H,3'd4,32'h15, L,L,H,32'h0,  H,L,L,L,L,L,32'h0,32'h0});
    tbl.push_back('{H,H,L,H,3'd4,32'h15, L,L,L,32'h0,  L,L,L,L,H,L,32'h0,32'h0});
    tbl.push_back('{H,L,L,L,3'd0,32'h0,  L,L,L,32'h0,  L,L,L,L,L,L,32'h0,32'h0});
    tbl.push_back('{L,H,H,L,3'd2,32'h0,  H,H,L,32'h0,  L,L,H,H,L,L,32'h0,32'h0});
    tbl.push_back('{H,H,H,L,3'd2,32'h0,  H,H,L,32'h0,  L,L,L,H,L,L,32'h0,32'h0});
    tbl.push_back('{H,H,L,L,3'd2,32'h0,  H,H,H,32'h0,  H,H,L,H,L,L,32'h0,32'h0});
    tbl.push_back('{H,L,L,L,3'd0,32'h0,  H,H,L,32'h0,  L,L,L,L,H,L,32'h0,32'h0});
    tbl.push_back('{H,L,L,L,3'd0,32'h0,  H,L,H,32'h17, H,H,L,L,L,L,32'h0,32'h0});
    tbl.push_back('{H,H,H,L,3'd1,32'h0,  H,H,L,32'h0,  L,L,L,H,L,H,32'h0,32'h17});
    tbl.push_back('{H,H,L,L,3'd1,32'h0,  H,H,H,32'h0,  H,H,L,H,L,L,32'h0,32'h0});
    tbl.push_back('{H,L,L,L,3'd0,32'h0,  H,H,L,32'h0,  L,L,L,L,H,L,32'h0,32'h0});
    tbl.push_back('{H,L,L,L,3'd0,32'h0,  H,L,H,32'h5A, H,H,L,L,L,L,32'h0,32'h0});
    tbl.push_back('{H,L,L,L,3'd0,32'h0,  L,L,L,32'h0,  L,L,L,L,L,H,32'h0,32'h5A});
    tbl.push_back('{H,L,L,L,3'd0,32'h0,  L,L,L,32'h0,  L,L,L,L,L,L,32'h0,32'h0});

    for (int i = 0; i < tbl.size(); i++) begin
      rst_n = tbl[i].rst; m0_cyc = tbl[i].c0; m0_stb = tbl[i].s0; m0_we = tbl[i].we0;
      m0_adr = tbl[i].adr0; m0_wdat = tbl[i].d0; m1_cyc = tbl[i].c1; m1_stb = tbl[i].s1;
      s_ack = tbl[i].ack; s_rdat = tbl[i].sdat;
      @(negedge clk);
      chk1($sformatf("row%0d s_cyc", i), s_cyc, tbl[i].e_cyc);
      chk1($sformatf("row%0d s_stb", i), s_stb, tbl[i].e_stb);
      chk1($sformatf("row%0d m0_stall", i), m0_stall, tbl[i].e_st0);
      chk1($sformatf("row%0d m1_stall", i), m1_stall, tbl[i].e_st1);
      chk1($sformatf("row%0d m0_ack", i), m0_ack, tbl[i].e_ack0);
      chk1($sformatf("row%0d m1_ack", i), m1_ack, tbl[i].e_ack1);
      chk32($sformatf("row%0d m0_dat", i), m0_rdat, tbl[i].e_dat0);
      chk32($sformatf("row%0d m1_dat", i), m1_rdat, tbl[i].e_dat1);
      finish_cycle();
    end

    // Slave never answers: m0 gets one err TIMEOUT cycles after ISSUE entry, then m1 runs.
    idle_inputs();
    m0_cyc = 1; m0_stb = 1;
    @(negedge clk);
    chk1("to grant m0_stall", m0_stall, 1'b0);
    finish_cycle();
    m0_stb = 0; m1_cyc = 1; m1_stb = 1;
    for (int k = 1; k <= TO + 1; k++) begin
      @(negedge clk);
      chk1($sformatf("to k%0d s_cyc", k), s_cyc, k <= TO);
      chk1($sformatf("to k%0d m0_err", k), m0_err, k > TO);
      chk1($sformatf("to k%0d m1_stall", k), m1_stall, k <= TO);
      finish_cycle();
    end
    m1_stb = 0; s_ack = 1;
    @(negedge clk);
    chk1("to m1 s_stb", s_stb, 1'b1);
    chk1("to m0_err once", m0_err, 1'b0);
    finish_cycle();
    s_ack = 0; m1_cyc = 0;
    @(negedge clk);
    chk1("to m1_ack", m1_ack, 1'b1);
    finish_cycle();

    // Slave stalls 3 cycles: stb held 4 cycles with latched request stable.
    idle_inputs();
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 3'd3; m0_wdat = 32'hA5A5; s_stall = 1;
    @(negedge clk);
    chk1("st grant m0_stall", m0_stall, 1'b0);
    finish_cycle();
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) s_stall = 0;
      @(negedge clk);
      chk1($sformatf("st k%0d s_stb", k), s_stb, 1'b1);
      chk32($sformatf("st k%0d s_adr", k), 32'(s_adr), 32'd3);
      chk32($sformatf("st k%0d s_dat", k), s_wdat, 32'hA5A5);
      chk1($sformatf("st k%0d m0_stall", k), m0_stall, 1'b1);
      finish_cycle();
    end
    m0_stb = 0; s_ack = 1;
    @(negedge clk);
    chk1("st wait s_stb", s_stb, 1'b0);
    chk1("st wait s_cyc", s_cyc, 1'b1);
    finish_cycle();
    s_ack = 0; m0_cyc = 0;
    @(negedge clk);
    chk1("st m0_ack", m0_ack, 1'b1);
    finish_cycle();

    // Reset while waiting: everything clears and a late ack is dropped.
    idle_inputs();
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 3'd7; m0_wdat = 32'hDEAD;
    finish_cycle();
    m0_stb = 0;
    @(negedge clk);
    chk1("rw issue s_stb", s_stb, 1'b1);
    finish_cycle();
    rst_n = 0;
    @(negedge clk);
    chk1("rw wait s_cyc", s_cyc, 1'b1);
    chk1("rw wait s_stb", s_stb, 1'b0);
    finish_cycle();
    rst_n = 1; s_ack = 1;
    @(negedge clk);
    chk1("rw rst s_cyc", s_cyc, 1'b0);
    chk1("rw rst s_stb", s_stb, 1'b0);
    chk1("rw rst s_we", s_we, 1'b0);
    chk32("rw rst s_adr", 32'(s_adr), 32'd0);
    chk32("rw rst s_sel", 32'(s_sel), 32'd0);
    chk32("rw rst s_dat", s_wdat, 32'd0);
    chk1("rw rst m0_ack", m0_ack, 1'b0);
    chk1("rw rst m0_err", m0_err, 1'b0);
    chk32("rw rst m0_dat", m0_rdat, 32'd0);
    finish_cycle();
    s_ack = 0;
    @(negedge clk);
    chk1("rw late m0_ack", m0_ack, 1'b0);
    chk1("rw late m0_err", m0_err, 1'b0);
    finish_cycle();

    for (int n = 0; n < 1500; n++) begin
      rst_n   = ($urandom_range(0, 49) != 0);
      m0_cyc  = ($urandom_range(0, 9) < 8);
      m0_stb  = m0_cyc & ($urandom_range(0, 1) == 1);
      m0_we   = ($urandom_range(0, 1) == 1);
      m0_adr  = 3'($urandom);
      m0_sel  = 4'($urandom);
      m0_wdat = $urandom;
      m1_cyc  = ($urandom_range(0, 9) < 8);
      m1_stb  = m1_cyc & ($urandom_range(0, 1) == 1);
      m1_we   = ($urandom_range(0, 1) == 1);
      m1_adr  = 3'($urandom);
      m1_sel  = 4'($urandom);
      m1_wdat = $urandom;
      s_ack   = ($urandom_range(0, 3) == 0);
      s_err   = ($urandom_range(0, 9) == 0);
      s_rty   = ($urandom_range(0, 1) == 1);
      s_stall = ($urandom_range(0, 2) == 0);
      s_rdat  = $urandom;
      @(negedge clk);
      finish_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
